// File: rtl/tetris_board.sv
// Playfield occupancy store with a single-cell write/read port
// and a line-clear engine that collapses full rows downward.
module tetris_board #(
    parameter int W  = 10,
    parameter int H  = 20,
    parameter int XW = 4,
    parameter int YW = 5,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr,
    input  logic          we,
    input  logic [XW-1:0] wx,
    input  logic [YW-1:0] wy,
    input  logic          wdata,
    input  logic [XW-1:0] rx,
    input  logic [YW-1:0] ry,
    output logic          rdata,
    input  logic          clear_start,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] lines_cleared
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [XW-1:0] XMAX = XW'(W - 1);
    localparam logic [YW-1:0] YMAX = YW'(H - 1);

    state_t        state;
    logic [W-1:0]  board [H];
    logic [YW-1:0] r;
    logic [CW-1:0] c;

    logic row_full;
    logic wr_ok;
    logic rd_ok;

    assign row_full = &board[r];
    assign wr_ok    = we && (state == IDLE) && (wx <= XMAX) && (wy <= YMAX);
    assign rd_ok    = (rx <= XMAX) && (ry <= YMAX);
    assign rdata    = rd_ok ? board[ry][rx] : 1'b0;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < H; i++) begin
                board[i] <= '0;
            end
            state         <= IDLE;
            r             <= '0;
            c             <= '0;
            done          <= 1'b0;
            lines_cleared <= '0;
        end else if (clr) begin
            for (int i = 0; i < H; i++) begin
                board[i] <= '0;
            end
            state         <= IDLE;
            r             <= '0;
            c             <= '0;
            done          <= 1'b0;
            lines_cleared <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wr_ok) begin
                        board[wy][wx] <= wdata;
                    end
                    if (clear_start) begin
                        r     <= YMAX;
                        c     <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // r stays put after a shift so the row dropped in is rechecked
                    if (row_full) begin
                        for (int k = 1; k < H; k++) begin
                            if (k <= int'(r)) begin
                                board[k] <= board[k-1];
                            end
                        end
                        board[0] <= '0;
                        c        <= c + 1'b1;
                    end else if (r == '0) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        lines_cleared <= c;
                    end else begin
                        r <= r - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_board.sv
// Directed bench for tetris_board: vector table for cell access,
// hand-written sequences for clear passes and aborts.
module tb_tetris_board;

    logic       clk;
    logic       resetn;
    logic       clr;
    logic       we;
    logic [3:0] wx;
    logic [4:0] wy;
    logic       wdata;
    logic [3:0] rx;
    logic [4:0] ry;
    logic       rdata;
    logic       clear_start;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;

    int checks = 0;
    int errors = 0;

    logic [9:0] model [20];

    tetris_board dut (
        .clk(clk),
        .resetn(resetn),
        .clr(clr),
        .we(we),
        .wx(wx),
        .wy(wy),
        .wdata(wdata),
        .rx(rx),
        .ry(ry),
        .rdata(rdata),
        .clear_start(clear_start),
        .busy(busy),
        .done(done),
        .lines_cleared(lines_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [3:0] wx;
        logic [4:0] wy;
        logic       wdata;
        logic [3:0] rx;
        logic [4:0] ry;
        logic       exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int y = 0; y < 20; y++) model[y] = '0;
    endtask

    task automatic check_board(input string name);
        logic [9:0] row;
        for (int y = 0; y < 20; y++) begin
            row = '0;
            for (int x = 0; x < 10; x++) begin
                rx = 4'(x);
                ry = 5'(y);
                #1;
                row[x] = rdata;
            end
            chk($sformatf("%s row%0d", name, y), int'(row), int'(model[y]));
        end
    endtask

    task automatic wr(input int x, input int y, input logic d);
        @(negedge clk);
        we = 1'b1;
        wx = 4'(x);
        wy = 5'(y);
        wdata = d;
        @(negedge clk);
        we = 1'b0;
        if (x < 10 && y < 20) model[y][x] = d;
    endtask

    task automatic fill_row(input int y);
        for (int x = 0; x < 10; x++) wr(x, y, 1'b1);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    // inject > 0: at that busy cycle try a write and a second clear_start
    task automatic run_pass(input string name, input int exp_busy,
                            input int exp_lc, input int inject);
        int cnt;
        int ndone;
        int done_at;
        cnt = 0;
        ndone = 0;
        done_at = -1;
        @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        while (busy && cnt < 100) begin
            cnt++;
            if (done) begin
                ndone++;
                done_at = cnt;
            end
            if (inject > 0 && cnt == inject) begin
                we = 1'b1;
                wx = 4'd5;
                wy = 5'd10;
                wdata = 1'b0;
                clear_start = 1'b1;
            end else begin
                we = 1'b0;
                clear_start = 1'b0;
            end
            @(negedge clk);
        end
        we = 1'b0;
        clear_start = 1'b0;
        chk({name, " busy_len"}, cnt, exp_busy);
        chk({name, " done_count"}, ndone, 1);
        chk({name, " done_last"}, done_at, exp_busy);
        chk({name, " lines"}, int'(lines_cleared), exp_lc);
        chk({name, " done_low"}, int'(done), 0);
    endtask

    task automatic watch_idle(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        chk({name, " stays_idle"}, seen, 0);
    endtask

    initial begin
        resetn = 1'b0;
        clr = 1'b0;
        we = 1'b0;
        wx = '0;
        wy = '0;
        wdata = 1'b0;
        rx = '0;
        ry = '0;
        clear_start = 1'b0;
        model_clear();

        vecs[0] = '{1'b1, 4'd3,  5'd7,  1'b1, 4'd3,  5'd7,  1'b1};
        vecs[1] = '{1'b0, 4'd0,  5'd0,  1'b0, 4'd15, 5'd7,  1'b0};
        vecs[2] = '{1'b1, 4'd15, 5'd7,  1'b1, 4'd15, 5'd7,  1'b0};
        vecs[3] = '{1'b1, 4'd3,  5'd25, 1'b1, 4'd3,  5'd25, 1'b0};
        vecs[4] = '{1'b1, 4'd9,  5'd19, 1'b1, 4'd9,  5'd19, 1'b1};
        vecs[5] = '{1'b1, 4'd9,  5'd19, 1'b0, 4'd9,  5'd19, 1'b0};
        vecs[6] = '{1'b1, 4'd0,  5'd0,  1'b1, 4'd0,  5'd0,  1'b1};
        vecs[7] = '{1'b1, 4'd0,  5'd0,  1'b0, 4'd0,  5'd0,  1'b0};
        vecs[8] = '{1'b0, 4'd0,  5'd0,  1'b0, 4'd3,  5'd7,  1'b1};
        vecs[9] = '{1'b1, 4'd3,  5'd7,  1'b0, 4'd3,  5'd7,  1'b0};

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset lines", int'(lines_cleared), 0);
        resetn = 1'b1;
        @(negedge clk);
        check_board("reset");

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            we = vecs[i].we;
            wx = vecs[i].wx;
            wy = vecs[i].wy;
            wdata = vecs[i].wdata;
            rx = vecs[i].rx;
            ry = vecs[i].ry;
            @(negedge clk);
            we = 1'b0;
            chk($sformatf("vec%0d rdata", i), int'(rdata), int'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d status", i),
                int'({busy, done, lines_cleared}), 0);
        end

        run_pass("empty", 21, 0, 0);
        check_board("empty");

        fill_row(19);
        wr(0, 18, 1'b1);
        run_pass("single", 22, 1, 0);
        model_clear();
        model[19] = 10'b0000000001;
        check_board("single");

        do_clr();
        fill_row(19);
        fill_row(17);
        fill_row(16);
        wr(0, 18, 1'b1);
        run_pass("noncontig", 24, 3, 0);
        model_clear();
        model[19] = 10'b0000000001;
        check_board("noncontig");

        do_clr();
        wr(5, 10, 1'b1);
        run_pass("busy_write", 21, 0, 3);
        check_board("busy_write");
        watch_idle("busy_start", 30);

        do_clr();
        fill_row(0);
        run_pass("row0", 22, 1, 0);
        model_clear();
        check_board("row0");

        fill_row(19);
        wr(4, 12, 1'b1);
        @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_abort busy_before", int'(busy), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_abort busy", int'(busy), 0);
        chk("clr_abort lines", int'(lines_cleared), 0);
        model_clear();
        check_board("clr_abort");
        watch_idle("clr_abort", 30);

        fill_row(19);
        run_pass("pre_reset", 22, 1, 0);
        fill_row(19);
        @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_abort busy_before", int'(busy), 1);
        resetn = 1'b0;
        #1;
        chk("rst_abort busy", int'(busy), 0);
        chk("rst_abort done", int'(done), 0);
        chk("rst_abort lines", int'(lines_cleared), 0);
        model_clear();
        check_board("rst_abort");
        @(negedge clk);
        resetn = 1'b1;
        watch_idle("rst_abort", 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
